// File: rtl/regfile_write_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | regfile_write_arbiter_pkg                                          |
// | Shared width derivations for the register-file write arbiter.      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package regfile_write_arbiter_pkg;

  // The result is never below 1 bit, so a count of 1 still gives a usable vector.
  function automatic int unsigned index_width(input int unsigned count);
    return (count <= 1) ? 1 : $clog2(count);
  endfunction

  function automatic int unsigned addr_width(input int unsigned bit_width);
    return index_width(bit_width);
  endfunction

  function automatic int unsigned ptr_width(input int unsigned requesters);
    return index_width(requesters);
  endfunction

endpackage : regfile_write_arbiter_pkg
`default_nettype wire

// File: rtl/rr_priority_pick.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rr_priority_pick                                                   |
// | Round-robin find-first: rotate by ptr, pick lowest, un-rotate.     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module rr_priority_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [PW-1:0] o_idx,
  output logic          o_valid
);

  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;
  logic           w_found;
  int unsigned    w_first;
  int unsigned    w_sum;

  assign w_dbl = {i_req, i_req};

  always_comb begin
    w_rot   = '0;
    w_found = 1'b0;
    w_first = 0;
    w_sum   = 0;
    o_grant = '0;
    o_idx   = '0;
    // Bit k of the rotated vector is requester (ptr + k) mod N.
    for (int k = 0; k < N; k++) begin
      w_rot[k] = w_dbl[k + int'(i_ptr)];
    end
    for (int k = 0; k < N; k++) begin
      if (!w_found && w_rot[k]) begin
        w_found = 1'b1;
        w_first = k;
      end
    end
    w_sum = w_first + int'(i_ptr);
    if (w_sum >= N) begin
      w_sum = w_sum - N;
    end
    if (w_found) begin
      o_idx          = PW'(w_sum);
      o_grant[o_idx] = 1'b1;
    end
  end

  assign o_valid = w_found;

endmodule : rr_priority_pick
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | regfile_write_arbiter                                              |
// | Round-robin share of the register-file write port, registered out. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int P_Requesters = 4,
  parameter int P_BitWidth   = 32,
  parameter int P_DataWidth  = 32,
  localparam int AW = addr_width(P_BitWidth),
  localparam int PW = ptr_width(P_Requesters)
) (
  input  logic                              In_Clock,
  input  logic                              In_Reset_n,
  input  logic [P_Requesters-1:0]           In_Request,
  input  logic [P_Requesters*AW-1:0]        In_Address,
  input  logic [P_Requesters*P_DataWidth-1:0] In_Data,
  input  logic                              In_Stall,
  output logic [P_Requesters-1:0]           Out_Grant,
  output logic [AW-1:0]                     Out_DecAddress,
  output logic                              Out_DecEnable,
  output logic [P_DataWidth-1:0]            Out_WriteData,
  output logic                              Out_Busy
);

  logic [PW-1:0]           r_ptr;
  logic [P_Requesters-1:0] w_req_eff;
  logic [P_Requesters-1:0] w_grant;
  logic [PW-1:0]           w_idx;
  logic                    w_any;

  // A stall hides every request from the picker, so nothing wins and Ptr holds.
  assign w_req_eff = In_Stall ? '0 : In_Request;

  rr_priority_pick #(
    .N  (P_Requesters),
    .PW (PW)
  ) u_pick (
    .i_req   (w_req_eff),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_valid (w_any)
  );

  assign Out_Grant = In_Reset_n ? w_grant : '0;

  always_ff @(posedge In_Clock or negedge In_Reset_n) begin
    if (!In_Reset_n) begin
      r_ptr          <= '0;
      Out_DecEnable  <= 1'b0;
      Out_DecAddress <= '0;
      Out_WriteData  <= '0;
      Out_Busy       <= 1'b0;
    end else begin
      Out_Busy      <= |In_Request;
      Out_DecEnable <= w_any;
      if (w_any) begin
        Out_DecAddress <= In_Address[w_idx*AW +: AW];
        Out_WriteData  <= In_Data[w_idx*P_DataWidth +: P_DataWidth];
        r_ptr          <= (w_idx == PW'(P_Requesters - 1)) ? '0 : w_idx + 1'b1;
      end
    end
  end

endmodule : regfile_write_arbiter
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_regfile_write_arbiter                                           |
// | Directed self-checking bench for the round-robin write arbiter.    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_regfile_write_arbiter;

  localparam int N   = 4;
  localparam int AW  = 5;
  localparam int DW  = 32;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] data;
  logic            stall;
  logic [N-1:0]    grant;
  logic [AW-1:0]   dec_addr;
  logic            dec_en;
  logic [DW-1:0]   wdata;
  logic            busy;

  int n_cmp;
  int n_bad;

  regfile_write_arbiter #(
    .P_Requesters (N),
    .P_BitWidth   (32),
    .P_DataWidth  (DW)
  ) dut (
    .In_Clock       (clk),
    .In_Reset_n     (rst_n),
    .In_Request     (req),
    .In_Address     (addr),
    .In_Data        (data),
    .In_Stall       (stall),
    .Out_Grant      (grant),
    .Out_DecAddress (dec_addr),
    .Out_DecEnable  (dec_en),
    .Out_WriteData  (wdata),
    .Out_Busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Inputs change 2 time units after a rising edge; checks follow 1 unit later.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  logic [N-1:0] exp_seq [5];

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    req   = '0;
    addr  = '0;
    data  = '0;
    stall = 1'b0;
    for (int i = 0; i < N; i++) begin
      addr[i*AW +: AW] = AW'(i + 20);
      data[i*DW +: DW] = 32'hA000_0000 + i;
    end

    // Reset state
    #3;
    check_eq("rst_grant", grant, 0);
    check_eq("rst_en", dec_en, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_addr", dec_addr, 0);
    check_eq("rst_data", wdata, 0);
    step();
    rst_n = 1'b1;

    // Idle after reset
    for (int c = 0; c < 3; c++) begin
      step();
      check_eq("idle_grant", grant, 0);
      check_eq("idle_en", dec_en, 0);
      check_eq("idle_busy", busy, 0);
    end

    // Single request from requester 2
    addr[2*AW +: AW] = 5'd9;
    data[2*DW +: DW] = 32'hDEADBEEF;
    req = 4'b0100;
    #1 check_eq("single_grant", grant, 4'b0100);
    step();
    req = '0;
    #1;
    check_eq("single_en", dec_en, 1);
    check_eq("single_addr", dec_addr, 9);
    check_eq("single_data", wdata, 32'hDEADBEEF);
    check_eq("single_busy", busy, 1);
    check_eq("single_grant_after", grant, 0);
    step();
    #1 check_eq("single_en_drop", dec_en, 0);

    // Ptr is now 3: wrap-around from requester 3 to requester 0
    addr[3*AW +: AW] = 5'd7;
    data[3*DW +: DW] = 32'h3333_0003;
    addr[0*AW +: AW] = 5'd4;
    data[0*DW +: DW] = 32'h0000_0C0C;
    req = 4'b1001;
    #1 check_eq("wrap_grant3", grant, 4'b1000);
    step();
    #1;
    check_eq("wrap_grant0", grant, 4'b0001);
    check_eq("wrap_addr3", dec_addr, 7);
    check_eq("wrap_data3", wdata, 32'h3333_0003);
    step();
    req = '0;
    #1;
    check_eq("wrap_addr0", dec_addr, 4);
    check_eq("wrap_data0", wdata, 32'h0000_0C0C);
    check_eq("wrap_en0", dec_en, 1);
    step();

    // All four continuously requesting from reset
    pulse_reset();
    for (int i = 0; i < N; i++) begin
      addr[i*AW +: AW] = AW'(i + 16);
      data[i*DW +: DW] = 32'hC0DE_0000 + i;
    end
    exp_seq[0] = 4'b0001;
    exp_seq[1] = 4'b0010;
    exp_seq[2] = 4'b0100;
    exp_seq[3] = 4'b1000;
    exp_seq[4] = 4'b0001;
    req = 4'b1111;
    #1;
    for (int c = 0; c < 5; c++) begin
      check_eq("rr_grant", grant, exp_seq[c]);
      step();
      #1;
      check_eq("rr_en", dec_en, 1);
      check_eq("rr_addr", dec_addr, 16 + (c % N));
      check_eq("rr_data", wdata, 32'hC0DE_0000 + (c % N));
    end
    req = '0;
    step();

    // Stall with two pending requests; one grant right before to see enable fall
    pulse_reset();
    req = 4'b0011;
    #1 check_eq("prestall_grant", grant, 4'b0001);
    step();
    stall = 1'b1;
    req = 4'b0011;
    #1 check_eq("prestall_en", dec_en, 1);
    for (int c = 0; c < 3; c++) begin
      check_eq("stall_grant", grant, 0);
      step();
      #1;
      check_eq("stall_en", dec_en, 0);
      check_eq("stall_busy", busy, 1);
    end
    stall = 1'b0;
    // Ptr was 1 before the stall, so requester 1 wins first
    #1 check_eq("unstall_grant", grant, 4'b0010);
    step();
    #1;
    check_eq("unstall_en", dec_en, 1);
    check_eq("unstall_grant2", grant, 4'b0001);
    step();
    req = '0;
    step();

    // Async reset during an in-flight write; Ptr would otherwise be 2
    req = 4'b0010;
    #1 check_eq("inflight_grant", grant, 4'b0010);
    step();
    req = '0;
    #1 check_eq("inflight_en", dec_en, 1);
    rst_n = 1'b0;
    #1;
    check_eq("async_en", dec_en, 0);
    check_eq("async_addr", dec_addr, 0);
    check_eq("async_busy", busy, 0);
    req = 4'b1010;
    #1 check_eq("async_grant_forced", grant, 0);
    rst_n = 1'b1;
    #1 check_eq("post_rst_grant", grant, 4'b0010);
    step();
    #1;
    check_eq("post_rst_en", dec_en, 1);
    check_eq("post_rst_addr", dec_addr, 17);
    check_eq("post_rst_next", grant, 4'b1000);
    req = '0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_regfile_write_arbiter
`default_nettype wire

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the register-file write port between P_Requesters independent writers.
- Each cycle, selects at most one pending write using round-robin priority.
- Registers the winner's address, enable and data into the AddressDecoder stage, so the register bank sees one registered one-hot write per cycle.
- Sits directly upstream of AddressDecoder.
  - Out_DecAddress drives the decoder's In_Address.
  - Out_DecEnable drives the decoder's In_Enable.
  - Out_WriteData feeds the bank's shared write-data bus.

Parameters:
- P_Requesters, 4: number of write requesters; minimum 2.
- P_BitWidth, 32: number of registers, equal to the decoder's P_BitWidth. AW = $clog2(P_BitWidth).
- P_DataWidth, 32: write-data width.

Ports:
- In_Clock  input  1  system clock, rising edge.
- In_Reset_n  input  1  asynchronous, active-low reset.
- In_Request  input  P_Requesters  per-requester write request, level.
- In_Address  input  P_Requesters*AW  packed; requester i occupies bits [i*AW +: AW].
- In_Data  input  P_Requesters*P_DataWidth  packed; requester i occupies bits [i*P_DataWidth +: P_DataWidth].
- In_Stall  input  1  downstream stall; blocks new grants.
- Out_Grant  output  P_Requesters  one-hot grant, combinational, same cycle as the request.
- Out_DecAddress  output  AW  registered write address to the decoder.
- Out_DecEnable  output  1  registered write enable to the decoder.
- Out_WriteData  output  P_DataWidth  registered write data.
- Out_Busy  output  1  registered; high while any request was pending at the last edge.

Behaviour:
- Clock and reset:
  - Single clock domain.
  - In_Reset_n low, asynchronously: Ptr=0, Out_DecEnable=0, Out_DecAddress=0, Out_WriteData=0, Out_Busy=0.
  - Out_Grant is forced to 0 while reset is asserted.
- Priority pointer Ptr:
  - Width $clog2(P_Requesters); reset value 0.
  - The requester at index Ptr has highest priority. The search order is Ptr, Ptr+1, …, wrapping modulo P_Requesters.
- Grant, combinational:
  - If In_Stall=0 and In_Request≠0, Out_Grant is one-hot at the first requesting index in search order.
  - Otherwise Out_Grant=0.
  - A requester seeing its grant bit high has its write accepted at that edge. It deasserts its request, or presents its next write, at the same edge.
- Registered stage, on each rising edge:
  - When any grant is high with index g:
    - Out_DecAddress ← In_Address slice g.
    - Out_WriteData ← In_Data slice g.
    - Out_DecEnable ← 1.
    - Ptr ← (g+1) mod P_Requesters, wrapping from P_Requesters-1 to 0.
  - When no grant is high: Out_DecEnable ← 0, and Ptr, Out_DecAddress and Out_WriteData hold.
  - Latency: grant cycle t, then the decoder enable is high in cycle t+1 for exactly one cycle per grant.
- Simultaneous requests:
  - Exactly one grant per cycle; losers keep requesting.
  - Starvation bound: a continuously requesting source is granted within P_Requesters cycles of unstalled operation.
- In_Stall:
  - When high: no grant, Ptr holds, Out_DecEnable is 0 in the following cycle.
  - Pending requests are preserved by the requesters.
- Out_Busy ← |In_Request, sampled every edge regardless of stall.
- Address range: an address ≥ P_BitWidth (non-power-of-2 P_BitWidth) is passed through unmodified. Range checking is the requester's responsibility.
- Reset mid-operation: a write in flight in the registered stage is dropped (Out_DecEnable falls immediately), and Ptr returns to 0.

Decomposition:
- Shared package: the AW and pointer-width derivations ($clog2 of P_BitWidth and of P_Requesters).
- One natural sub-module, rr_priority_pick: combinational rotate, find-first, un-rotate. Inputs are the request vector and Ptr; outputs are the one-hot grant and the encoded index g.
- The registered stage and Ptr update live in the top level.

Test Plan:
- Reset, then all inputs 0 → Out_Grant=0, Out_DecEnable=0, Out_Busy=0 at every cycle.
- Single request: In_Request=4'b0100, addr2=5'd9, data2=32'hDEADBEEF.
  - Same cycle: Out_Grant=4'b0100.
  - Next cycle: Out_DecEnable=1, Out_DecAddress=9, Out_WriteData=32'hDEADBEEF.
  - Ptr becomes 3.
- All four requesting continuously from reset → grants in order 0001, 0010, 0100, 1000, 0001. Out_DecEnable is high every cycle from cycle 1.
- Ptr=3 with In_Request=4'b1001 → grant 1000, then 0001 (wrap-around check).
- Stall: In_Request=4'b0011, In_Stall=1 for 3 cycles.
  - During the stall: no grants, Out_DecEnable=0, Ptr unchanged, Out_Busy=1.
  - After release: grant 0001 first.
- Reset asserted asynchronously while Out_DecEnable=1 → Out_DecEnable=0 before the next clock edge. After release, requests 4'b1010 produce grant 0010 first (Ptr=0).
